// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the controller state encoding and the iteration-counter width helper.
// No ports; imported by mult_seq and its adder.
package mult_seq_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MULT_N = 16;

  // Counter must hold the values 0..n, so it needs clog2(n+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(MULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_seq_adder.sv
// Purpose : n-bit ripple adder producing {cout, sum} = a + b + cin.
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : a_i, b_i (n bits), cin_i (1) -> sum_o (n bits), cout_o (1).
module mult_seq_adder #(
  parameter int n = 16
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         cin_i,
  output logic [n-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{n{1'b0}}, cin_i};

endmodule

// File: rtl/mult_seq.sv
// Purpose : multi-cycle shift-add N x N multiplier, unsigned or two's complement.
// Latency : done pulses N+1 edges after the edge that accepts start.
// Backpr. : start is only honoured in IDLE; requests while busy or done are dropped.
// Ports   : clk, rst (sync, active-high); start, is_signed, a, b in;
//           busy, done (1-cycle pulse), product (2N bits, held until next start) out.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);

  mult_state_t state_q, state_d;

  logic [N-1:0]   ma_q, ma_d;       // multiplicand magnitude
  logic [N-1:0]   hi_q, hi_d;       // partial-product high half
  logic [N-1:0]   lo_q, lo_d;       // multiplier bits, replaced by product low bits
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;     // result sign, applied at FIX
  logic [2*N-1:0] product_q, product_d;

  logic [N-1:0]   a_mag, b_mag;
  logic [N-1:0]   addend;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly the right magnitude (e.g. 0x8000 -> 32768).
  assign a_mag = (is_signed && a[N-1]) ? -a : a;
  assign b_mag = (is_signed && b[N-1]) ? -b : b;

  assign addend = lo_q[0] ? ma_q : '0;

  mult_seq_adder #(.n(N)) u_adder (
    .a_i    (hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so they are glitch-free.
  always_comb begin
    busy = (state_q == RUN) || (state_q == FIX);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    ma_d      = ma_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d  = a_mag;
          hi_d  = '0;
          lo_d  = b_mag;
          cnt_d = '0;
          neg_d = is_signed & (a[N-1] ^ b[N-1]);
        end
      end
      RUN: begin
        // {cout, sum, lo} shifted right by one: carry enters hi's MSB and
        // sum's LSB drops into lo as the next settled product bit.
        hi_d  = {add_cout, add_sum[N-1:1]};
        lo_d  = {add_sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        product_d = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      ma_q      <= ma_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           is_signed;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an accepting edge; counts edges until done is seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    bit got;
    got      = 0;
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
  endtask

  // Full operation: accept, scramble inputs, wait, check latency/busy/product,
  // then confirm done lasted one cycle only.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic sv, input logic [2*N-1:0] exp);
    int edges, bc;
    @(negedge clk);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'hA5A5; b = 16'h5A5A; is_signed = ~sv;
    wait_done(edges, bc);
    chk({tag, "_lat"}, 64'(edges), 64'd17);
    chk({tag, "_busy"}, 64'(bc), 64'd17);
    chk({tag, "_prod"}, 64'(product), 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int edges, bc, pulses;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", 64'(product), 64'd0);
    rst = 1'b0;

    run_op("u3x5",    16'd3,    16'd5,    1'b0, 32'h0000000F);
    run_op("umax",    16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    run_op("sneg",    16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
    run_op("smin2",   16'h8000, 16'h8000, 1'b1, 32'h40000000);
    run_op("smin1",   16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);

    // Start held high through the whole op with different operands: ignored
    // while busy, then accepted one edge after done.
    @(negedge clk);
    a = 16'd2; b = 16'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd9; b = 16'd9;
    wait_done(edges, bc);
    chk("ign_lat", 64'(edges), 64'd17);
    chk("ign_prod", 64'(product), 64'd6);
    @(posedge clk); #1;
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    chk("b2b_prod_hold", 64'(product), 64'd6);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_prod_run", 64'(product), 64'd6);
    wait_done(edges, bc);
    chk("b2b_lat", 64'(edges), 64'd12);
    chk("b2b_prod", 64'(product), 64'h51);
    @(posedge clk); #1;

    // Reset partway through a run aborts it.
    @(negedge clk);
    a = 16'h1234; b = 16'h0010; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", 64'(product), 64'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    run_op("zero",    16'h0000, 16'h1234, 1'b0, 32'h00000000);
    run_op("szero",   16'h0000, 16'hFFFF, 1'b1, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle shift-add multiplier for the datapath: N x N operands produce a 2N-bit product.
- Each cycle it feeds the existing adder (n = N) with the partial-product high half and the multiplicand, then consumes {cout, sum} as the next partial product.
- It sits between the register-file read ports and the writeback mux. The controller handles it with a start/busy/done handshake.
- Both unsigned and signed (two's complement) operation are supported.

Parameters:
- N, 16, operand width; the product is 2N bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- a  input  N  multiplicand; sampled with start.
- b  input  N  multiplier; sampled with start.
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse; product is valid in that cycle.
- product  output  2N  registered result, held until the next accepted start.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, all internal registers = 0.
- States: IDLE, RUN, FIX, DONE. State is registered.
- IDLE:
  - If start = 1 at edge t, capture the magnitudes: ma = |a| and mb = |b| when is_signed, otherwise a and b.
  - Capture neg = is_signed & (a[N-1] ^ b[N-1]).
  - Load hi = 0, lo = mb, cnt = 0. Then busy = 1 and go to RUN.
- RUN, one step per edge:
  - {cout, sum} = hi + (lo[0] ? ma : 0) + 0, computed by the adder instance.
  - Update {hi, lo} <= {cout, sum, lo} >> 1, so the 2N+1-bit concatenation shifts right by one.
  - cnt <= cnt + 1. After N steps (edges t+1 .. t+N), go to FIX.
- FIX, at edge t+N+1:
  - product <= neg ? -{hi, lo} : {hi, lo}, using 2N-bit two's-complement negation.
  - Go to DONE. At the same edge, busy <= 0 and done <= 1.
- DONE:
  - done is high for exactly one cycle, then the block returns to IDLE and done goes to 0.
  - Latency: done is high in the cycle following edge t+N+1, i.e. N+1 edges after the accepting edge (17 for N = 16).
- start while in RUN, FIX or DONE is ignored; there is no queuing.
  - Back-to-back operation: start may be asserted in the cycle done is high, but it is accepted only on the following edge, once the block is back in IDLE.
- a, b and is_signed may change freely after the accepting edge; results use the captured values.
- The magnitude of the most negative value (e.g. 0x8000) is held as an N-bit unsigned value (32768). The 2N-bit product never overflows.
- Operand 0 runs the full N cycles; there is no early termination, so latency is fixed.
- Reset asserted mid-operation aborts the operation: there is no done pulse and product returns to 0.
- product does not change during RUN. It updates only at the FIX edge.

Decomposition:
- Shared package:
  - typedef mult_state_t enum {IDLE, RUN, FIX, DONE} (2 bits).
  - localparam CNT_W = $clog2(N+1).
- Sub-module: one instance of the existing adder, with #(.n(N)), cin tied 0, and cout feeding the shift.
- Magnitude extraction and final negation are inline logic, not separate modules.

Test Plan:
- Unsigned multiply: rst for 2 cycles, then start with a = 3, b = 5, is_signed = 0 -> busy = 1 for 17 cycles, done pulses once, product = 0x0000000F.
- Unsigned maximum: a = 0xFFFF, b = 0xFFFF, is_signed = 0 -> product = 0xFFFE0001.
- Signed negative result: a = 0xFFFD (-3), b = 0x0007, is_signed = 1 -> product = 0xFFFFFFEB (-21).
- Signed corner: a = 0x8000, b = 0x8000, is_signed = 1 -> product = 0x40000000. Also a = 0x8000, b = 0x0001 -> product = 0xFFFF8000.
- Ignored start: start = 1 with a = 9, b = 9 while busy -> ignored; the first op's product is unchanged. Then back-to-back: start held through done -> second op accepted one edge after done, with latency unchanged.
- Reset and zero: rst at cycle 8 of a run -> next cycle busy = 0, done = 0, product = 0, and no done pulse follows. Then a = 0, b = 0x1234 -> product = 0 after full latency.
